// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern path: command codes, parser state
// encoding and the serial_out frequency divider constants.
package serial_pkg;

  localparam logic [7:0] CMD_LOAD_OUT  = 8'h01;
  localparam logic [7:0] CMD_LOAD_FREQ = 8'h02;
  localparam logic [7:0] CMD_START_ONE = 8'h10;
  localparam logic [7:0] CMD_START_REP = 8'h11;
  localparam logic [7:0] CMD_STOP      = 8'h20;

  localparam int LOW_FREQ  = 9;
  localparam int HIGH_FREQ = 3;

  typedef enum logic {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } state_e;

  typedef enum logic {
    TGT_OUT  = 1'b0,
    TGT_FREQ = 1'b1
  } target_e;

endpackage

// File: rtl/cmd_parser_if.sv
// Byte stream in, committed patterns and control pulses out of the command parser.
// rx_valid is a one-clock strobe with no backpressure: rx_data is sampled on any
// rising edge where rx_valid is high, and there is no ready signal.
interface cmd_parser_if #(
  parameter int DATA_BIT = 32
);
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic [DATA_BIT-1:0] output_pattern;
  logic [DATA_BIT-1:0] freq_pattern;
  logic                mode;
  logic                start;
  logic                stop;
  logic                load_tick;
  logic                err_tick;

  modport master (
    output rx_valid, rx_data,
    input  output_pattern, freq_pattern, mode, start, stop, load_tick, err_tick
  );

  modport slave (
    input  rx_valid, rx_data,
    output output_pattern, freq_pattern, mode, start, stop, load_tick, err_tick
  );
endinterface

// File: rtl/timeout_counter.sv
// Idle-cycle counter with synchronous clear, count enable and terminal-count flag.
module timeout_counter #(
  parameter int W        = 1,
  parameter int TERMINAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/cmd_parser.sv
// UART byte-stream command parser: decodes commands, assembles LSB-first payload
// frames and commits them atomically to the output/frequency pattern registers.
module cmd_parser
  import serial_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int TIMEOUT  = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_mode,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_load_tick,
  output logic                o_err_tick,
  output state_e              o_dbg_state
);

  localparam int NBYTE = DATA_BIT / 8;
  localparam int BCW   = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam int TCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  target_e             target_q, target_d;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [DATA_BIT-1:0] staging_q, staging_d;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
  logic [DATA_BIT-1:0] freq_pat_q, freq_pat_d;
  logic                mode_q, mode_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic                timeout_tc;

  // Clearing on the terminal count keeps the counter from wrapping on the abort edge.
  timeout_counter #(
    .W        (TCW),
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  ((state_q != S_DATA) || i_rx_valid || timeout_tc),
    .enable_i (state_q == S_DATA),
    .tc_o     (timeout_tc)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    byte_cnt_d = byte_cnt_q;
    staging_d  = staging_q;
    out_pat_d  = out_pat_q;
    freq_pat_d = freq_pat_q;
    mode_d     = mode_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    load_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_CMD: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD_OUT, CMD_LOAD_FREQ: begin
              target_d   = (i_rx_data == CMD_LOAD_FREQ) ? TGT_FREQ : TGT_OUT;
              byte_cnt_d = '0;
              staging_d  = '0;
              state_d    = S_DATA;
            end
            CMD_START_ONE, CMD_START_REP: begin
              mode_d  = i_rx_data[0];
              start_d = 1'b1;
            end
            CMD_STOP: stop_d = 1'b1;
            default:  err_d  = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        // A byte arriving on the terminal-count cycle wins over the timeout.
        if (i_rx_valid) begin
          staging_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_data;
          if (byte_cnt_q == BCW'(NBYTE - 1)) begin
            if (target_q == TGT_FREQ) freq_pat_d = staging_d;
            else                      out_pat_d  = staging_d;
            load_d  = 1'b1;
            state_d = S_CMD;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (timeout_tc) begin
          staging_d = '0;
          err_d     = 1'b1;
          state_d   = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CMD;
      target_q   <= TGT_OUT;
      byte_cnt_q <= '0;
      staging_q  <= '0;
      out_pat_q  <= '0;
      freq_pat_q <= '0;
      mode_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      byte_cnt_q <= byte_cnt_d;
      staging_q  <= staging_d;
      out_pat_q  <= out_pat_d;
      freq_pat_q <= freq_pat_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

  assign o_output_pattern = out_pat_q;
  assign o_freq_pattern   = freq_pat_q;
  assign o_mode           = mode_q;
  assign o_start          = start_q;
  assign o_stop           = stop_q;
  assign o_load_tick      = load_q;
  assign o_err_tick       = err_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: directed command scenarios plus randomized byte streams,
// every cycle compared against a frame-level reference model.
module tb_cmd_parser;
  import serial_pkg::*;

  localparam int DATA_BIT = 32;
  localparam int TIMEOUT  = 16;
  localparam int NBYTE    = DATA_BIT / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_parser_if #(.DATA_BIT(DATA_BIT)) bus ();
  state_e dbg_state;

  cmd_parser #(
    .DATA_BIT (DATA_BIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rx_valid       (bus.rx_valid),
    .i_rx_data        (bus.rx_data),
    .o_output_pattern (bus.output_pattern),
    .o_freq_pattern   (bus.freq_pattern),
    .o_mode           (bus.mode),
    .o_start          (bus.start),
    .o_stop           (bus.stop),
    .o_load_tick      (bus.load_tick),
    .o_err_tick       (bus.err_tick),
    .o_dbg_state      (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [DATA_BIT-1:0] m_out, m_freq;
  logic                m_mode;
  logic [3:0]          m_ticks;   // {start, stop, load, err}
  bit                  m_in_frame;
  bit                  m_tgt_freq;
  logic [7:0]          m_bytes[$];
  int                  m_idle;

  function automatic void model_reset();
    m_out      = '0;
    m_freq     = '0;
    m_mode     = 1'b0;
    m_ticks    = '0;
    m_in_frame = 0;
    m_tgt_freq = 0;
    m_idle     = 0;
    m_bytes.delete();
  endfunction

  // Outputs expected right after the clock edge that sees (v, d).
  function automatic void model_step(bit v, logic [7:0] d);
    logic [DATA_BIT-1:0] word;
    m_ticks = '0;
    if (!m_in_frame) begin
      if (v) begin
        case (d)
          8'h01, 8'h02: begin
            m_in_frame = 1;
            m_tgt_freq = (d == 8'h02);
            m_idle     = 0;
            m_bytes.delete();
          end
          8'h10, 8'h11: begin
            m_mode  = d[0];
            m_ticks = 4'b1000;
          end
          8'h20:   m_ticks = 4'b0100;
          default: m_ticks = 4'b0001;
        endcase
      end
    end else if (v) begin
      m_bytes.push_back(d);
      m_idle = 0;
      if (m_bytes.size() == NBYTE) begin
        word = '0;
        for (int k = 0; k < NBYTE; k++) word = word + (DATA_BIT'(m_bytes[k]) << (8 * k));
        if (m_tgt_freq) m_freq = word;
        else            m_out  = word;
        m_ticks    = 4'b0010;
        m_in_frame = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_ticks    = 4'b0001;
        m_in_frame = 0;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("out_pattern",  64'(bus.output_pattern), 64'(m_out));
    check_eq("freq_pattern", 64'(bus.freq_pattern),   64'(m_freq));
    check_eq("mode",         64'(bus.mode),           64'(m_mode));
    check_eq("ticks",        64'({bus.start, bus.stop, bus.load_tick, bus.err_tick}), 64'(m_ticks));
    check_eq("in_frame",     64'(dbg_state == S_DATA), 64'(m_in_frame));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input bit v, input logic [7:0] d);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'($urandom));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0, 8'h00);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h10;
      3:       return 8'h11;
      4:       return 8'h20;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    apply_reset();

    // load output pattern
    send(1, 8'h01); send(1, 8'hEF); send(1, 8'hBE); send(1, 8'hAD); send(1, 8'hDE);
    check_eq("deadbeef", 64'(bus.output_pattern), 64'h0000_0000_DEAD_BEEF);
    idle(2);

    // load freq pattern then start repeat
    send(1, 8'h02); send(1, 8'h0F); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    check_eq("freq_0f", 64'(bus.freq_pattern), 64'h0000_0000_0000_000F);
    send(1, 8'h11);
    check_eq("start_rep", 64'({bus.mode, bus.start}), 64'h3);
    idle(1);

    // partial frame times out
    apply_reset();
    send(1, 8'h01); send(1, 8'h11); send(1, 8'h22);
    idle(TIMEOUT);
    check_eq("timeout_err", 64'({bus.err_tick, bus.output_pattern}), {31'b0, 1'b1, 32'h0});
    send(1, 8'h20);
    check_eq("stop_after_to", 64'(bus.stop), 64'h1);

    // unknown code then start one-shot
    send(1, 8'h7F);
    send(1, 8'h10);
    check_eq("start_one", 64'({bus.mode, bus.start}), 64'h1);

    // command values inside a payload are data
    send(1, 8'h01); send(1, 8'h20); send(1, 8'h10); send(1, 8'h11); send(1, 8'h01);
    check_eq("cmd_as_data", 64'(bus.output_pattern), 64'h0000_0000_0111_1020);

    // reset mid-frame, then a clean frame
    send(1, 8'h01); send(1, 8'h44); send(1, 8'h33);
    apply_reset();
    send(1, 8'h01); send(1, 8'h44); send(1, 8'h33); send(1, 8'h22); send(1, 8'h11);
    check_eq("after_rst", 64'(bus.output_pattern), 64'h0000_0000_1122_3344);

    // byte landing exactly on the terminal-count cycle is accepted
    send(1, 8'h02);
    idle(TIMEOUT - 1); send(1, 8'hA5);
    idle(TIMEOUT - 1); send(1, 8'h5A);
    send(1, 8'hC3); send(1, 8'h3C);
    check_eq("tc_boundary", 64'(bus.freq_pattern), 64'h0000_0000_3CC3_5AA5);

    // randomized streams
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 19))
        0:       apply_reset();
        1:       idle($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
        2, 3:    idle($urandom_range(1, 3));
        default: send(1'b1, rand_byte());
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
